// File: rtl/rf_writeback_if.sv
// ---------------------------------------------------------------------------
// rf_writeback_if
// LSU -> writeback write-offer channel.
//   valid : LSU has a write result to offer this cycle
//   ready : writeback queue can accept (valid & ready = transfer)
//   addr  : destination register
//   data  : result value
// Modports: master = LSU side, slave = writeback controller side.
// ---------------------------------------------------------------------------
interface rf_writeback_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/rf_writeback.sv
// ---------------------------------------------------------------------------
// rf_writeback
// Writeback-side controller for the integer register file. Owns the file's
// single write port and chooses at most one write per cycle between the ALU
// result and the head of an in-order LSU write queue. Writes to x0 are
// dropped. A busy scoreboard reports registers with a queued write.
//
// Optional feature (macro RF_WB_BYPASS_EN): corrects the register file's
// old-data return when a read and a write hit the same register on the same
// edge. Without the macro, read data passes straight through.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   alu_valid/alu_addr/alu_data     single-cycle ALU write request
//   lsu (rf_writeback_if.slave)     LSU write offer (valid/ready/addr/data)
//   wb_stall                        queue full; pipeline must hold ALU request
//   chk_addr1/2 -> chk_busy1/2      hazard query: register has a queued write
//   rf_we/rf_w_addr/rf_w_data       registered register-file write port
//   rd_addr1/2, rd_raw1/2           read address / raw data at the file
//   rd_data1/2                      corrected read data to decode
// ---------------------------------------------------------------------------
module rf_writeback #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,

    rf_writeback_if.slave         lsu,

    output logic                  wb_stall,

    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,

    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [WIDTH-1:0]      rf_w_data,

    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    input  logic [WIDTH-1:0]      rd_raw1,
    input  logic [WIDTH-1:0]      rd_raw2,
    output logic [WIDTH-1:0]      rd_data1,
    output logic [WIDTH-1:0]      rd_data2
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Queue storage holds data only; occupancy lives in the pointers/count.
    logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
    logic [WIDTH-1:0]      q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic                  sel_we_p0;
    logic [ADDR_WIDTH-1:0] sel_addr_p0;
    logic [WIDTH-1:0]      sel_data_p0;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign wb_stall = full;
    // Held low during reset so no offer is accepted while state is cleared.
    assign lsu.ready = !full && !rst;
    // x0 offers complete the handshake but are never queued.
    assign push     = lsu.valid && lsu.ready && (lsu.addr != '0);

    // ---- stage p0: write-source selection ----
    always_comb begin
        pop         = 1'b0;
        sel_we_p0   = 1'b0;
        sel_addr_p0 = alu_addr;
        sel_data_p0 = alu_data;
        if (full) begin
            // A full queue must drain; the ALU request is held by wb_stall.
            pop         = 1'b1;
            sel_we_p0   = 1'b1;
            sel_addr_p0 = q_addr[rd_ptr];
            sel_data_p0 = q_data[rd_ptr];
        end else if (alu_valid && (alu_addr != '0)) begin
            sel_we_p0   = 1'b1;
        end else if (!empty) begin
            // Also reached for an ALU write to x0, which is simply consumed.
            pop         = 1'b1;
            sel_we_p0   = 1'b1;
            sel_addr_p0 = q_addr[rd_ptr];
            sel_data_p0 = q_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= lsu.addr;
            q_data[wr_ptr] <= lsu.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scoreboard: an entry is live when its distance from the head is below
    // the occupancy count. A popped entry stops reporting busy as soon as it
    // moves onto the write port.
    always_comb begin
        logic [PTR_W-1:0] off;
        chk_busy1 = 1'b0;
        chk_busy2 = 1'b0;
        off       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if (CNT_W'(off) < count) begin
                if ((q_addr[i] == chk_addr1) && (chk_addr1 != '0)) chk_busy1 = 1'b1;
                if ((q_addr[i] == chk_addr2) && (chk_addr2 != '0)) chk_busy2 = 1'b1;
            end
        end
    end

    // ---- stage p1: registered register-file write port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
        end else begin
            rf_we     <= sel_we_p0;
            rf_w_addr <= sel_addr_p0;
            rf_w_data <= sel_data_p0;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic             hit1_p2;
    logic             hit2_p2;
    logic [WIDTH-1:0] byp_data_p2;

    // ---- stage p2: capture same-edge write/read collisions ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit1_p2     <= 1'b0;
            hit2_p2     <= 1'b0;
            byp_data_p2 <= '0;
        end else begin
            hit1_p2     <= rf_we && (rf_w_addr == rd_addr1) && (rd_addr1 != '0);
            hit2_p2     <= rf_we && (rf_w_addr == rd_addr2) && (rd_addr2 != '0);
            byp_data_p2 <= rf_w_data;
        end
    end

    assign rd_data1 = hit1_p2 ? byp_data_p2 : rd_raw1;
    assign rd_data2 = hit2_p2 ? byp_data_p2 : rd_raw2;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};

    assign rd_data1 = rd_raw1;
    assign rd_data2 = rd_raw2;
`endif

endmodule
